// File: rtl/rv32i_types.sv
// Shared types for the burst-memory responder: output FSM states, the 256-bit
// line viewed as four 64-bit words, and the read-queue entry.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } bmem_state_t;

  // Word k occupies bits [64k+63:64k].
  typedef logic [3:0][63:0] bmem_line_t;

  typedef struct packed {
    logic [31:0] addr;
    bmem_line_t  line;
  } bmem_rq_entry_t;

  function automatic logic [31:0] line_align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

endpackage

// File: rtl/bmem_read_queue.sv
// QDEPTH-entry FIFO of {line address, 256-bit line} snapshots for pending reads.
module bmem_read_queue
  import rv32i_types::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  bmem_rq_entry_t            push_ent_i,
  input  logic                      pop_i,
  output bmem_rq_entry_t            head_o,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] DEPTH_C = QDEPTH[PW:0];

  bmem_rq_entry_t ent_q [QDEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q;

  // Payload storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk)
    if (push_i) ent_q[wr_ptr_q] <= push_ent_i;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end

  assign head_o  = ent_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bmem_responder.sv
// Burst-memory responder: 4-beat writes into a local line array, reads snapshot
// a whole line into a queue and return it as 4 beats after LATENCY idle cycles.
module bmem_responder
  import rv32i_types::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 8,
  parameter int QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);
  localparam int CW = $clog2(QDEPTH) + 1;

  bmem_line_t mem_q [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] req_idx, wr_idx_q, mem_widx;
  logic [1:0]           wr_beat_q, mem_wword, beat_q, nxt_beat;
  logic                 wr_active_q, alive_q, protocol_err_q, mem_we;
  logic                 wr_accept, rd_accept, pop;
  bmem_state_t          state_q;
  logic [7:0]           wait_cnt_q;
  logic                 rvalid_q;
  logic [63:0]          rdata_q;
  logic [31:0]          raddr_q;
  logic                 q_full, q_empty;
  logic [CW-1:0]        q_count;
  bmem_rq_entry_t       q_head, q_push_ent;
  logic                 unused_bits;

  assign req_idx    = bmem_addr[ADDR_BITS+4:5];
  // alive_q keeps ready low through reset and until the first edge after release.
  assign bmem_ready = alive_q && !wr_active_q && !q_full;
  assign wr_accept  = bmem_ready && bmem_write;
  assign rd_accept  = bmem_ready && bmem_read && !bmem_write;
  assign pop        = (state_q == BURST) && (beat_q == 2'd3);
  assign nxt_beat   = beat_q + 2'd1;
  assign unused_bits = ^{bmem_addr[4:0], q_count};

  assign q_push_ent = '{addr: line_align(bmem_addr), line: mem_q[req_idx]};

  // Single array write port shared by the first beat and the latched follow-on beats.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = req_idx;
    mem_wword = 2'd0;
    if (wr_accept) begin
      mem_we = 1'b1;
    end else if (wr_active_q) begin
      mem_we    = bmem_write;
      mem_widx  = wr_idx_q;
      mem_wword = wr_beat_q;
    end
  end

  always_ff @(posedge clk)
    if (mem_we) mem_q[mem_widx][mem_wword] <= bmem_wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alive_q        <= 1'b0;
      wr_active_q    <= 1'b0;
      wr_beat_q      <= 2'd0;
      wr_idx_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (wr_accept) begin
        wr_active_q <= 1'b1;
        wr_beat_q   <= 2'd1;
        wr_idx_q    <= req_idx;
        if (bmem_read) protocol_err_q <= 1'b1;
      end else if (wr_active_q) begin
        // A missing beat is skipped but still consumes its slot.
        if (!bmem_write) protocol_err_q <= 1'b1;
        wr_beat_q <= wr_beat_q + 2'd1;
        if (wr_beat_q == 2'd3) wr_active_q <= 1'b0;
      end
    end

  bmem_read_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rd_accept),
    .push_ent_i (q_push_ent),
    .pop_i      (pop),
    .head_o     (q_head),
    .count_o    (q_count),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  // Beat outputs are loaded on the edge entering each beat cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      beat_q     <= 2'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'd0;
      raddr_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (!q_empty) begin
          wait_cnt_q <= 8'(LATENCY - 1);
          state_q    <= WAIT;
        end
        WAIT: if (wait_cnt_q == 8'd0) begin
          state_q  <= BURST;
          beat_q   <= 2'd0;
          rvalid_q <= 1'b1;
          rdata_q  <= q_head.line[0];
          raddr_q  <= q_head.addr;
        end else begin
          wait_cnt_q <= wait_cnt_q - 8'd1;
        end
        BURST: if (beat_q == 2'd3) begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end else begin
          beat_q  <= nxt_beat;
          rdata_q <= q_head.line[nxt_beat];
        end
        default: state_q <= IDLE;
      endcase
    end

  assign bmem_rvalid = rvalid_q;
  assign bmem_rdata  = rdata_q;
  assign bmem_raddr  = raddr_q;

endmodule

// File: tb/tb_bmem_responder.sv
// Self-checking bench for bmem_responder: line-level memory model plus an
// expected-burst queue compared against the beats observed on the read port.
module tb_bmem_responder;
  import rv32i_types::*;

  localparam int LAT = 8;
  localparam int QD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bmem_addr;
  logic        bmem_read, bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready, bmem_rvalid;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;

  int checks = 0, failures = 0, cyc = 0, last_accept = 0;

  typedef struct { int cyc; logic [31:0] addr; logic [63:0] data; } beat_t;
  typedef struct { int cyc; logic [31:0] addr; logic [255:0] line; } req_t;
  beat_t        obs[$];
  req_t         exp_q[$];
  int           starts[$];
  logic [255:0] model [int];

  bmem_responder #(.ADDR_BITS(10), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (bmem_rvalid) obs.push_back('{cyc: cyc, addr: bmem_raddr, data: bmem_rdata});

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[14:5]);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bmem_read = 1'b0; bmem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bmem_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ready_timeout: ready=%b required 1 within 200 cycles", bmem_ready);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input int drop, input bit rd_too);
    bit ok;
    logic [255:0] cur;
    wait_ready(ok);
    if (!ok) return;
    bmem_addr = addr; bmem_write = 1'b1; bmem_read = rd_too; bmem_wdata = line[63:0];
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      bmem_read = 1'b0;
      bmem_addr = $urandom;
      checks++;
      if (bmem_ready !== 1'b0) begin
        failures++;
        $display("FAIL write_ready_low: beat %0d ready=%b required 0", b, bmem_ready);
      end
      bmem_write = (b != drop);
      bmem_wdata = line[64*b +: 64];
    end
    @(negedge clk);
    bmem_write = 1'b0;
    checks++;
    if (bmem_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_ready_back: ready=%b required 1", bmem_ready);
    end
    cur = model.exists(idx_of(addr)) ? model[idx_of(addr)] : '0;
    for (int b = 0; b < 4; b++)
      if (b != drop) cur[64*b +: 64] = line[64*b +: 64];
    model[idx_of(addr)] = cur;
  endtask

  task automatic do_read(input logic [31:0] addr);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bmem_addr = addr; bmem_read = 1'b1;
    last_accept = cyc + 1;
    exp_q.push_back('{cyc: last_accept, addr: {addr[31:5], 5'b0}, line: model[idx_of(addr)]});
    @(negedge clk);
    bmem_read = 1'b0;
  endtask

  task automatic check_bursts();
    req_t  e;
    beat_t o;
    int    first, budget;
    budget = 0;
    while (obs.size() < 4 * exp_q.size() && budget < 2000) begin
      @(negedge clk); budget++;
    end
    if (obs.size() < 4 * exp_q.size()) begin
      checks++; failures++;
      $display("FAIL burst_timeout: beats=%0d required %0d", obs.size(), 4 * exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() >= 4) begin
      e = exp_q.pop_front();
      first = obs[0].cyc;
      starts.push_back(first);
      for (int k = 0; k < 4; k++) begin
        o = obs.pop_front();
        checks++;
        if (o.addr !== e.addr || o.data !== e.line[64*k +: 64] || o.cyc != first + k) begin
          failures++;
          $display("FAIL beat%0d: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   k, o.addr, o.data, o.cyc, e.addr, e.line[64*k +: 64], first + k);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; bmem_read = 1'b0; bmem_write = 1'b0; bmem_addr = '0; bmem_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bmem_ready !== 1'b0 || bmem_rvalid !== 1'b0 || bmem_rdata !== 64'd0 || bmem_raddr !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rvalid=%b rdata=%h raddr=%h required 0/0/0/0",
               bmem_ready, bmem_rvalid, bmem_rdata, bmem_raddr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bmem_ready !== 1'b1 || dut.protocol_err_q !== 1'b0 || dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL reset_release: ready=%b perr=%b state=%0d required 1/0/IDLE",
               bmem_ready, dut.protocol_err_q, dut.state_q);
    end
  endtask

  task automatic test_write_read();
    do_write(32'h1eceb000, {64'h4, 64'h3, 64'h2, 64'h1}, -1, 1'b0);
    starts.delete();
    do_read(32'h1eceb010);
    check_bursts();
    checks++;
    if (starts.size() != 1 || starts[0] != last_accept + LAT + 1) begin
      failures++;
      $display("FAIL read_latency: first beat cycle=%0d required %0d",
               (starts.size() > 0) ? starts[0] : -1, last_accept + LAT + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [5];
    int acc5;
    for (int i = 0; i < 5; i++) begin
      a[i] = {$urandom_range(0, 255), 24'h0} | ((100 + 7 * i) << 5);
      do_write(a[i], {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, -1, 1'b0);
    end
    starts.delete();
    for (int i = 0; i < 4; i++) do_read(a[i]);
    checks++;
    if (bmem_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: ready=%b required 0 after 4th accept", bmem_ready);
    end
    do_read(a[4]);
    acc5 = last_accept;
    check_bursts();
    checks++;
    if (starts.size() != 5 || acc5 != starts[0] + 5) begin
      failures++;
      $display("FAIL fifth_accept: accept=%0d required %0d", acc5, starts[0] + 5);
    end
    for (int i = 0; i + 1 < starts.size(); i++) begin
      checks++;
      if (starts[i+1] - starts[i] != LAT + 5) begin
        failures++;
        $display("FAIL burst_period: gap=%0d required %0d", starts[i+1] - starts[i], LAT + 5);
      end
    end
  endtask

  task automatic test_read_then_write();
    logic [31:0] a = 32'h0000_2a40;
    do_write(a, {4{64'hdead_beef_0000_0001}}, -1, 1'b0);
    do_read(a);
    do_write(a, {4{64'h1234_5678_9abc_def0}}, -1, 1'b0);
    do_read(a);
    check_bursts();
  endtask

  task automatic test_random();
    logic [31:0] pool [16];
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      pool[i] = ($urandom_range(0, 1023) << 5);
      do_write(pool[i], {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, -1, 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      a = pool[$urandom_range(0, 15)];
      a = {$urandom_range(0, 131071), a[14:5], 5'(($urandom_range(0, 31)))};
      if ($urandom_range(0, 2) == 0)
        do_write(a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, -1, 1'b0);
      else
        do_read(a);
    end
    check_bursts();
  endtask

  task automatic test_reset_mid_burst();
    bit seen = 1'b0;
    do_read(32'h1eceb000);
    do_read(32'h0000_2a40);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (bmem_rvalid === 1'b1);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (!seen || bmem_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rvalid: seen=%b rvalid=%b required 1/0", seen, bmem_rvalid);
    end
    exp_q.delete(); obs.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (bmem_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready_low: ready=%b required 0", bmem_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bmem_ready !== 1'b1 || dut.q_count !== '0) begin
      failures++;
      $display("FAIL rst_release: ready=%b count=%0d required 1/0", bmem_ready, dut.q_count);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin
      failures++;
      $display("FAIL rst_no_beats: beats=%0d required 0", obs.size());
    end
  endtask

  task automatic test_rw_collision();
    logic [31:0] a = 32'h0000_5560;
    checks++;
    if (dut.protocol_err_q !== 1'b0) begin
      failures++;
      $display("FAIL perr_clear: perr=%b required 0", dut.protocol_err_q);
    end
    do_write(a, {64'hc3, 64'hc2, 64'hc1, 64'hc0}, -1, 1'b1);
    checks++;
    if (dut.protocol_err_q !== 1'b1) begin
      failures++;
      $display("FAIL collision_perr: perr=%b required 1", dut.protocol_err_q);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin
      failures++;
      $display("FAIL collision_no_read: beats=%0d required 0", obs.size());
    end
    do_read(a);
    check_bursts();
  endtask

  task automatic test_write_drop();
    logic [31:0] a = 32'h0000_7fe0;
    apply_reset();
    checks++;
    if (dut.protocol_err_q !== 1'b0) begin
      failures++;
      $display("FAIL drop_perr_reset: perr=%b required 0", dut.protocol_err_q);
    end
    do_write(a, {64'ha3, 64'ha2, 64'ha1, 64'ha0}, -1, 1'b0);
    do_write(a, {64'hb3, 64'hb2, 64'hb1, 64'hb0}, 2, 1'b0);
    checks++;
    if (dut.protocol_err_q !== 1'b1) begin
      failures++;
      $display("FAIL drop_perr: perr=%b required 1", dut.protocol_err_q);
    end
    do_read(a);
    check_bursts();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_then_write();
    test_random();
    test_reset_mid_burst();
    test_rw_collision();
    test_write_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
